// File: rtl/msi_irq_ctrl.sv
// Per-tile MSI interrupt controller: latches MSI pulses as pending bits, masks them and
// presents the lowest-index enabled line to the core over a req/ack handshake.
module msi_irq_ctrl #(
    parameter int IRQ_NUM_POW = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [31:0]               host_addr,
    input  logic [31:0]               host_wdata,
    output logic                      host_ack,
    output logic                      host_resp,
    output logic [31:0]               host_rdata,
    input  logic                      msi_req_i,
    input  logic [2**IRQ_NUM_POW-1:0] msi_code_bi,
    output logic                      irq_req_o,
    output logic [IRQ_NUM_POW-1:0]    irq_code_bo,
    input  logic                      irq_ack_i
);

    localparam int N = 2**IRQ_NUM_POW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [7:0] ADDR_PENDING = 8'h00;
    localparam logic [7:0] ADDR_MASK    = 8'h04;
    localparam logic [7:0] ADDR_STATUS  = 8'h08;

    logic [0:0]             state;
    logic [N-1:0]           pending;
    logic [N-1:0]           mask;
    logic [N-1:0]           enabled;
    logic [N-1:0]           set_bits;
    logic [N-1:0]           host_clr;
    logic [N-1:0]           ack_clr;
    logic [IRQ_NUM_POW-1:0] next_code;
    logic [31:0]            rd_mux;
    logic                   wr_en;
    logic                   rd_en;
    logic                   served;

    assign host_ack  = host_req;
    assign wr_en     = host_req & host_we;
    assign rd_en     = host_req & ~host_we;
    assign irq_req_o = (state == ST_REQ);
    assign served    = (state == ST_REQ) & irq_ack_i;
    assign enabled   = pending & mask;
    assign set_bits  = msi_req_i ? msi_code_bi : '0;
    assign host_clr  = (wr_en && host_addr[7:0] == ADDR_PENDING) ? host_wdata[N-1:0] : '0;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ack_clr = '0;
        if (served)
            ack_clr[irq_code_bo] = 1'b1;
    end

    // Descending scan so the lowest enabled index is the last (winning) assignment.
    always_comb begin
        next_code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (enabled[i])
                next_code = i[IRQ_NUM_POW-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (host_addr[7:0])
            ADDR_PENDING: rd_mux[N-1:0] = pending;
            ADDR_MASK:    rd_mux[N-1:0] = mask;
            ADDR_STATUS: begin
                rd_mux[31]              = irq_req_o;
                rd_mux[IRQ_NUM_POW-1:0] = irq_code_bo;
            end
            default:      rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            pending     <= '0;
            mask        <= '0;
            irq_code_bo <= '0;
            host_resp   <= 1'b0;
            host_rdata  <= '0;
        end else begin
            // Set is OR-ed after the clear so a coincident MSI is never lost.
            pending   <= (pending & ~(host_clr | ack_clr)) | set_bits;
            host_resp <= rd_en;
            if (rd_en)
                host_rdata <= rd_mux;
            if (wr_en && host_addr[7:0] == ADDR_MASK)
                mask <= host_wdata[N-1:0];

            case (state)
                ST_IDLE: begin
                    if (|enabled) begin
                        irq_code_bo <= next_code;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Request stays up regardless of mask/W1C changes until the core acks.
                    if (irq_ack_i)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_irq_ctrl.sv
// Directed bench for msi_irq_ctrl: per-line behavioural model compared every cycle,
// plus hand-computed literal expectations along the directed scenarios.
module tb_msi_irq_ctrl;

    localparam int P = 4;
    localparam int N = 2**P;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          host_req;
    logic          host_we;
    logic [31:0]   host_addr;
    logic [31:0]   host_wdata;
    logic          host_ack;
    logic          host_resp;
    logic [31:0]   host_rdata;
    logic          msi_req_i;
    logic [N-1:0]  msi_code_bi;
    logic          irq_req_o;
    logic [P-1:0]  irq_code_bo;
    logic          irq_ack_i;

    int checks = 0;
    int errors = 0;

    msi_irq_ctrl #(.IRQ_NUM_POW(P)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_resp   (host_resp),
        .host_rdata  (host_rdata),
        .msi_req_i   (msi_req_i),
        .msi_code_bi (msi_code_bi),
        .irq_req_o   (irq_req_o),
        .irq_code_bo (irq_code_bo),
        .irq_ack_i   (irq_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one bit per line, a "serving" flag and the line being served.
    bit m_pend [N];
    bit m_mask [N];
    bit m_req;
    int m_code;
    bit m_resp;
    logic [31:0] m_rdata;
    bit started = 0;

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] v;
        v = 0;
        case (addr[7:0])
            8'h00: for (int i = 0; i < N; i++) v[i] = m_pend[i];
            8'h04: for (int i = 0; i < N; i++) v[i] = m_mask[i];
            8'h08: v = (m_req ? 32'h8000_0000 : 32'h0) + 32'(m_code);
            default: v = 0;
        endcase
        return v;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_mask[i] = 0;
            end
            m_req = 0; m_code = 0; m_resp = 0; m_rdata = 0;
            started = 1;
        end else if (started) begin
            bit new_pend [N];
            bit new_mask [N];
            int first;
            bit do_write;
            do_write = host_req && host_we;
            m_resp = host_req && !host_we;
            if (m_resp) m_rdata = model_read(host_addr);
            for (int i = 0; i < N; i++) begin
                bit clr;
                clr = (do_write && host_addr[7:0] == 8'h00 && host_wdata[i])
                      || (m_req && irq_ack_i && m_code == i);
                new_pend[i] = (msi_req_i && msi_code_bi[i]) || (m_pend[i] && !clr);
                new_mask[i] = (do_write && host_addr[7:0] == 8'h04) ? host_wdata[i] : m_mask[i];
            end
            if (m_req) begin
                if (irq_ack_i) m_req = 0;
            end else begin
                first = -1;
                for (int i = N - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) first = i;
                if (first >= 0) begin
                    m_req = 1;
                    m_code = first;
                end
            end
            m_pend = new_pend;
            m_mask = new_mask;
        end
    end

    always @(negedge clk_i) begin
        if (started && !rst_i) begin
            check("model irq_req", 32'(irq_req_o), 32'(m_req));
            check("model irq_code", 32'(irq_code_bo), 32'(m_code));
            check("model resp", 32'(host_resp), 32'(m_resp));
            check("model ack", 32'(host_ack), 32'(host_req));
            if (m_resp) check("model rdata", host_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
        host_req = 1; host_we = 1; host_addr = addr; host_wdata = data;
        tick();
        host_req = 0; host_we = 0;
    endtask

    task automatic host_read(input logic [31:0] addr, output logic [31:0] data);
        host_req = 1; host_we = 0; host_addr = addr;
        #1;
        check("ack same cycle", 32'(host_ack), 32'd1);
        tick();
        host_req = 0;
        check("resp after read", 32'(host_resp), 32'd1);
        data = host_rdata;
    endtask

    task automatic msi(input logic [N-1:0] code);
        msi_req_i = 1; msi_code_bi = code;
        tick();
        msi_req_i = 0; msi_code_bi = '0;
    endtask

    task automatic ack();
        irq_ack_i = 1;
        tick();
        irq_ack_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        rst_i = 1; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        msi_req_i = 0; msi_code_bi = 0; irq_ack_i = 0;
        tick(); tick();
        rst_i = 0;
        check("reset irq_req", 32'(irq_req_o), 32'd0);
        check("reset irq_code", 32'(irq_code_bo), 32'd0);
        check("reset resp", 32'(host_resp), 32'd0);
        check("reset rdata", host_rdata, 32'd0);

        // Masked line latches but does not request; unmasking raises it next edge.
        msi(16'h0010);
        host_read(32'h0, rd);
        check("masked pending", rd, 32'h0000_0010);
        check("masked no req", 32'(irq_req_o), 32'd0);
        host_write(32'h4, 32'h0010);
        check("req not yet", 32'(irq_req_o), 32'd0);
        tick();
        check("unmask req", 32'(irq_req_o), 32'd1);
        check("unmask code", 32'(irq_code_bo), 32'd4);
        ack();
        check("ack drops req", 32'(irq_req_o), 32'd0);

        // Priority order with one idle cycle between requests.
        host_write(32'h4, 32'hFFFF);
        msi(16'h8005);
        tick();
        check("prio code0", 32'(irq_code_bo), 32'd0);
        ack();
        check("idle gap 1", 32'(irq_req_o), 32'd0);
        tick();
        check("prio req2", 32'(irq_req_o), 32'd1);
        check("prio code2", 32'(irq_code_bo), 32'd2);
        ack();
        check("idle gap 2", 32'(irq_req_o), 32'd0);
        tick();
        check("prio code15", 32'(irq_code_bo), 32'd15);
        ack();
        host_read(32'h0, rd);
        check("all served pending", rd, 32'h0);
        check("all served no req", 32'(irq_req_o), 32'd0);

        // MSI on the served line coinciding with ack: set wins.
        msi(16'h0008);
        tick();
        check("code3", 32'(irq_code_bo), 32'd3);
        msi_req_i = 1; msi_code_bi = 16'h0008; irq_ack_i = 1;
        tick();
        msi_req_i = 0; msi_code_bi = 0; irq_ack_i = 0;
        check("set-wins gap", 32'(irq_req_o), 32'd0);
        host_read(32'h0, rd);
        check("set-wins pending", rd, 32'h0000_0008);
        check("set-wins re-req", 32'(irq_req_o), 32'd1);
        check("set-wins code", 32'(irq_code_bo), 32'd3);
        ack();

        // Register access.
        host_write(32'h4, 32'h00A5);
        host_read(32'h4, rd);
        check("mask readback", rd, 32'h0000_00A5);
        msi(16'h0020);
        tick();
        host_read(32'h8, rd);
        check("status", rd, 32'h8000_0005);
        ack();
        host_write(32'h4, 32'h0);
        msi(16'h0003);
        host_write(32'h0, 32'h0001);
        host_read(32'h0, rd);
        check("w1c", rd, 32'h0000_0002);
        host_write(32'h0, 32'hFFFF);
        host_write(32'hC, 32'hFFFF_FFFF);
        host_read(32'h10, rd);
        check("unmapped read", rd, 32'h0);

        // Request is held across mask clear and W1C of the served line.
        host_write(32'h4, 32'hFFFF);
        msi(16'h0002);
        tick();
        check("hold code1", 32'(irq_code_bo), 32'd1);
        host_write(32'h4, 32'h0);
        host_write(32'h0, 32'h0002);
        tick();
        check("hold req", 32'(irq_req_o), 32'd1);
        check("hold code", 32'(irq_code_bo), 32'd1);
        ack();
        tick(); tick();
        check("no req after hold", 32'(irq_req_o), 32'd0);

        // Reset in the middle of a request.
        host_write(32'h4, 32'hFFFF);
        msi(16'h00FF);
        tick();
        check("pre-reset req", 32'(irq_req_o), 32'd1);
        rst_i = 1;
        tick();
        rst_i = 0;
        check("rst drops req", 32'(irq_req_o), 32'd0);
        host_read(32'h0, rd);
        check("rst pending", rd, 32'h0);
        host_read(32'h4, rd);
        check("rst mask", rd, 32'h0);
        msi(16'h0004);
        tick(); tick();
        check("post-rst no req", 32'(irq_req_o), 32'd0);
        host_read(32'h0, rd);
        check("post-rst pending", rd, 32'h0000_0004);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msi_irq_ctrl.md
Name: msi_irq_ctrl

Overview:
- Per-tile interrupt controller directly downstream of the tile SFR block.
- Collects message-signalled interrupt (MSI) pulses as a bit-vector of IRQ lines and keeps them as pending bits.
- Applies a software mask and presents one prioritised interrupt at a time to the core with a req/ack handshake.
- Mask and pending state are accessed by software through a MemSplit32 slave port.

Parameters:
IRQ_NUM_POW, 4, log2 of number of IRQ lines; N = 2**IRQ_NUM_POW lines (N <= 32)

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous active-high reset
host  MemSplit32.Slave  -  register access (req, we, addr, wdata, ack, resp, rdata)
msi_req_i  input  1  single-cycle MSI strobe from SFR
msi_code_bi  input  N  bitmask of IRQ lines raised by this MSI
irq_req_o  output  1  interrupt request to core
irq_code_bo  output  IRQ_NUM_POW  index of requested IRQ
irq_ack_i  input  1  core accepts current request

Behaviour:
Reset (rst_i high at an edge):
- pending=0, mask=0, FSM=IDLE, irq_req_o=0, irq_code_bo=0, host.resp=0, host.rdata=0.
- Applies regardless of FSM state; an outstanding request is dropped without waiting for ack.

Registers (decoded on host.addr[7:0]):
- 0x0 PENDING: read returns pending zero-extended to 32 bits; write clears bits where wdata=1 (W1C).
- 0x4 MASK: read/write, wdata[N-1:0]; 1 = line enabled.
- 0x8 STATUS: read-only {irq_req_o at bit 31, zeros, irq_code_bo at [IRQ_NUM_POW-1:0]}.
- Other addresses: writes ignored, reads return 0.

Host protocol:
- host.ack = host.req combinationally.
- Read: host.resp=1 and host.rdata valid exactly one cycle after the req cycle. rdata holds its value until the next read.
- Write: no resp; takes effect at the req edge.
- resp is 0 in every other cycle.

Pending update at every edge:
- pending_next = (pending & ~clr) | set
- set = msi_req_i ? msi_code_bi : 0
- clr = host W1C bits | onehot(irq_code_bo) when (REQ state and irq_ack_i)
- Set wins over clear on the same bit in the same cycle, so a new event is never lost.
- MSI to an already-pending line merges (no counting).
- Masked lines still latch as pending.

FSM:
- IDLE: if |(pending & mask) on registered values, latch irq_code_bo = lowest set index of (pending & mask), set irq_req_o=1, go to REQ. Otherwise stay.
- REQ: irq_req_o and irq_code_bo are held stable.
  - A mask change or a W1C on the served line does not withdraw the request.
  - On irq_ack_i=1: irq_req_o<=0, the served pending bit is cleared (subject to set-wins), go to IDLE.
- irq_ack_i in IDLE is ignored.
- There is at least one cycle with irq_req_o=0 between consecutive requests.

Latency:
- msi_req_i sampled at edge E0 sets pending at E0.
- irq_req_o rises at E1, provided the FSM is IDLE and the line is enabled.
- Ack sampled at edge A: irq_req_o falls at A; the earliest next request rises at A+1.

Priority: lowest index wins; selection happens only at IDLE→REQ.

Test Plan:
- Reset then MASK=0x0000, MSI code 0x0010 -> PENDING reads 0x00000010, irq_req_o stays 0; then write MASK=0x0010 -> irq_req_o=1, irq_code_bo=4 next edge.
- MASK=0xFFFF, MSI code 0x8005 -> request code 0; ack -> one idle cycle, then code 2; ack -> code 15; ack -> PENDING=0, irq_req_o=0.
- In REQ with code 3, MSI 0x0008 coincides with irq_ack_i -> bit 3 stays pending, and a new request with code 3 follows after one idle cycle.
- Read MASK after writing 0x00A5 -> ack same cycle, resp=1 with rdata=0x000000A5 the next cycle. Read STATUS while requesting code 5 -> 0x80000005. W1C PENDING 0x0001 with pending 0x0003 -> reads 0x0002.
- In REQ with code 1, write MASK=0 and W1C 0x0002 -> irq_req_o and code 1 held until ack; after ack no new request.
- Assert rst_i for one cycle while in REQ with pending 0x00FF -> next cycle irq_req_o=0, PENDING=0, MASK=0; a subsequent MSI with MASK=0 raises no request.
